wci_cfg_sequencer: RTL and testbench

Autonomous WCI control-plane master that sequences configuration traffic into the mkSMAdapter4B wciS0 slave port during bitstream-generation test builds. It issues write/read-back pairs over a small address window, using data from an internal LFSR. It honours the OCP thread-busy and response handshakes and records error, mismatch and timeout status in sticky flags. It sits beside the RandomNumberGenerator instances in the *_random top level and drives wciS0_MCmd/MAddr/MData in place of top-level pins.

---
 rtl/wci_cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_wci_cfg_sequencer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wci_cfg_sequencer.sv
// wci_cfg_sequencer: autonomous WCI control-plane master that writes LFSR
// data across a small window, reads it back, and keeps sticky status.
module wci_cfg_sequencer #(
  parameter logic [19:0] BASE_ADDR  = 20'h00010,
  parameter int          ADDR_SPAN  = 16,
  parameter int          GAP_CYCLES = 2,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] SEED       = 32'hACE10001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  wciS0_MCmd,
  output logic        wciS0_MAddrSpace,
  output logic [3:0]  wciS0_MByteEn,
  output logic [19:0] wciS0_MAddr,
  output logic [31:0] wciS0_MData,
  input  logic [1:0]  wciS0_SResp,
  input  logic [31:0] wciS0_SData,
  input  logic        wciS0_SThreadBusy,
  output logic        busy,
  output logic [15:0] done_count,
  output logic        err_sticky,
  output logic        mismatch_sticky,
  output logic        timeout_sticky
);

  localparam logic [31:0] LFSR_INIT =
    (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [19:0] LAST_ADDR =
    BASE_ADDR + 20'(ADDR_SPAN - 4);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  localparam int WW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    GAP
  } state_t;

  state_t          state;
  state_t          nextState;
  logic            opRd;
  logic            nextOpRd;
  logic [19:0]     addr;
  logic [31:0]     lfsr;
  logic [WW-1:0]   waitCnt;
  logic [GW-1:0]   gapCnt;

  logic [31:0]     lfsrNext;
  logic [19:0]     addrNext;
  logic            pairDone;
  logic            errResp;
  logic            mismatch;
  logic            timedOut;

  assign lfsrNext = lfsr[0]
    ? ({1'b0, lfsr[31:1]} ^ LFSR_MASK)
    : {1'b0, lfsr[31:1]};

  assign addrNext = (addr == LAST_ADDR)
    ? BASE_ADDR
    : addr + 20'd4;

  always_comb begin
    nextState = state;
    nextOpRd  = opRd;
    pairDone  = 1'b0;
    errResp   = 1'b0;
    mismatch  = 1'b0;
    timedOut  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          nextState = ISSUE;
          nextOpRd  = 1'b0;
        end
      end
      ISSUE: begin
        if (wciS0_MCmd != 3'd0 &&
            !wciS0_SThreadBusy)
          nextState = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (wciS0_SResp == 2'd1 && !opRd) begin
          nextOpRd  = 1'b1;
          nextState = NO_GAP ? ISSUE : GAP;
        end else if (wciS0_SResp != 2'd0 ||
                     waitCnt == TO_LAST) begin
          // A write error or a timeout ends the pair without its read.
          pairDone  = 1'b1;
          errResp   = wciS0_SResp[1];
          mismatch  = (wciS0_SResp == 2'd1) &&
                      (wciS0_SData != lfsr);
          timedOut  = (wciS0_SResp == 2'd0);
          nextOpRd  = 1'b0;
          if (!NO_GAP)
            nextState = GAP;
          else if (enable)
            nextState = ISSUE;
          else
            nextState = IDLE;
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST)
          nextState = (opRd || enable) ? ISSUE : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      opRd             <= 1'b0;
      addr             <= BASE_ADDR;
      lfsr             <= LFSR_INIT;
      waitCnt          <= '0;
      gapCnt           <= '0;
      wciS0_MCmd       <= '0;
      wciS0_MAddrSpace <= 1'b0;
      wciS0_MByteEn    <= '0;
      wciS0_MAddr      <= '0;
      wciS0_MData      <= '0;
      busy             <= 1'b0;
      done_count       <= '0;
      err_sticky       <= 1'b0;
      mismatch_sticky  <= 1'b0;
      timeout_sticky   <= 1'b0;
    end else begin
      state   <= nextState;
      opRd    <= nextOpRd;
      busy    <= (nextState != IDLE);
      waitCnt <= (state == WAIT_RESP)
        ? waitCnt + WW'(1) : '0;
      gapCnt  <= (state == GAP)
        ? gapCnt + GW'(1) : '0;

      if (pairDone) begin
        done_count <= done_count + 16'd1;
        lfsr       <= lfsrNext;
        addr       <= addrNext;
      end

      err_sticky      <= err_sticky | errResp;
      mismatch_sticky <= mismatch_sticky | mismatch;
      timeout_sticky  <= timeout_sticky | timedOut;

      // Command fields are loaded on entry to ISSUE and held until accept.
      if (nextState == ISSUE) begin
        wciS0_MCmd       <= nextOpRd ? 3'd2 : 3'd1;
        wciS0_MAddrSpace <= 1'b1;
        wciS0_MByteEn    <= 4'hF;
        wciS0_MAddr      <= pairDone ? addrNext : addr;
        wciS0_MData      <= nextOpRd
          ? 32'd0
          : (pairDone ? lfsrNext : lfsr);
      end else begin
        wciS0_MCmd       <= '0;
        wciS0_MAddrSpace <= 1'b0;
        wciS0_MByteEn    <= '0;
        wciS0_MAddr      <= '0;
        wciS0_MData      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wci_cfg_sequencer.sv
// tb_wci_cfg_sequencer: directed scenarios against a transaction-level
// model of the sequencer, driven by a scripted WCI slave.
module tb_wci_cfg_sequencer;

  localparam logic [19:0] BASE = 20'h00010;
  localparam int          SPAN = 16;
  localparam int          GAP  = 2;
  localparam int          TMO  = 64;
  localparam logic [31:0] SEED = 32'hACE10001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  MCmd;
  logic        MAddrSpace;
  logic [3:0]  MByteEn;
  logic [19:0] MAddr;
  logic [31:0] MData;
  logic [1:0]  SResp = 2'd0;
  logic [31:0] SData = 32'd0;
  logic        SThreadBusy = 1'b0;
  logic        busy;
  logic [15:0] doneCount;
  logic        errS;
  logic        misS;
  logic        toS;

  wci_cfg_sequencer #(
    .BASE_ADDR (BASE),
    .ADDR_SPAN (SPAN),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO),
    .SEED      (SEED)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .wciS0_MCmd       (MCmd),
    .wciS0_MAddrSpace (MAddrSpace),
    .wciS0_MByteEn    (MByteEn),
    .wciS0_MAddr      (MAddr),
    .wciS0_MData      (MData),
    .wciS0_SResp      (SResp),
    .wciS0_SData      (SData),
    .wciS0_SThreadBusy(SThreadBusy),
    .busy             (busy),
    .done_count       (doneCount),
    .err_sticky       (errS),
    .mismatch_sticky  (misS),
    .timeout_sticky   (toS)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] kind;
    int         delay;
    bit         corrupt;
  } dir_t;

  dir_t        dirQ[$];
  logic [31:0] mem [logic [19:0]];

  logic [19:0] expAddr;
  logic [31:0] expLfsr;
  bit          expRd;
  int          expDone;
  bit          expErr;
  bit          expMis;
  bit          expTo;

  logic [19:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];
  logic [19:0] rdAddrLog[$];
  int          issueLens[$];
  int          accepts;
  int          issueLen;
  int          lastAcceptCyc;
  int          toDelta;
  int          firstDvaCyc;
  int          rdIssueCyc;
  bit          firstDvaSeen;
  bit          firstRdSeen;

  bit          pend;
  int          pendCnt;
  logic [1:0]  pendKind;
  logic [31:0] pendData;

  logic [2:0]  pCmd;
  logic [19:0] pAddr;
  logic [31:0] pData;
  bit          pHeld;
  bit          pTo;

  function automatic logic [31:0] lfsrStep(
    input logic [31:0] v
  );
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic accept();
    dir_t        d;
    logic [31:0] rd;
    d = (dirQ.size() > 0)
      ? dirQ.pop_front()
      : '{kind: 2'd1, delay: 2, corrupt: 1'b0};
    accepts++;
    lastAcceptCyc = cyc + 1;
    issueLens.push_back(issueLen);
    issueLen = 0;
    check(expRd ? "rdCmd" : "wrCmd",
          {MCmd, MAddr, MData},
          {expRd ? 3'd2 : 3'd1, expAddr,
           expRd ? 32'd0 : expLfsr});
    if (!expRd) begin
      mem[MAddr] = MData;
      wrAddrLog.push_back(MAddr);
      wrDataLog.push_back(MData);
    end else begin
      rdAddrLog.push_back(MAddr);
    end
    rd = mem.exists(MAddr) ? mem[MAddr] : 32'd0;
    if (d.corrupt) rd = 32'hDEADBEEF;
    pend     = (d.kind != 2'd0);
    pendCnt  = d.delay;
    pendKind = d.kind;
    pendData = expRd ? rd : 32'd0;
    if (d.kind == 2'd1 && !expRd) begin
      expRd = 1'b1;
    end else begin
      if (d.kind == 2'd0)      expTo  = 1'b1;
      else if (d.kind != 2'd1) expErr = 1'b1;
      else if (rd != expLfsr)  expMis = 1'b1;
      expDone++;
      expLfsr = lfsrStep(expLfsr);
      expAddr = BASE +
        20'((int'(expAddr - BASE) + 4) % SPAN);
      expRd = 1'b0;
    end
  endtask

  // Monitor: bus rules every cycle, model check on every accept.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (MCmd == 3'd0) begin
          check("idleBus",
                {MAddrSpace, MByteEn, MAddr, MData}, '0);
        end else begin
          check("cmdQual", {busy, MAddrSpace, MByteEn},
                {1'b1, 1'b1, 4'hF});
          if (pHeld)
            check("cmdStable", {MCmd, MAddr, MData},
                  {pCmd, pAddr, pData});
          issueLen++;
        end
        if (toS && !pTo) toDelta = cyc - lastAcceptCyc;
        pTo = toS;
        if (MCmd == 3'd2 && !firstRdSeen) begin
          firstRdSeen = 1'b1;
          rdIssueCyc  = cyc;
        end
        pHeld = 1'b0;
        if (MCmd != 3'd0) begin
          if (SThreadBusy) begin
            pHeld = 1'b1;
            pCmd  = MCmd;
            pAddr = MAddr;
            pData = MData;
          end else begin
            accept();
          end
        end
      end
    end
  end

  // Slave response driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      SResp = 2'd0;
      SData = 32'd0;
      if (pend) begin
        if (pendCnt == 0) begin
          SResp = pendKind;
          SData = pendData;
          pend  = 1'b0;
          if (pendKind == 2'd1 && !firstDvaSeen) begin
            firstDvaSeen = 1'b1;
            firstDvaCyc  = cyc;
          end
        end else begin
          pendCnt--;
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #2;
    reset       = 1'b0;
    enable      = 1'b0;
    SThreadBusy = 1'b0;
    pend        = 1'b0;
    dirQ.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    rdAddrLog.delete();
    issueLens.delete();
    expAddr = BASE;
    expLfsr = SEED;
    expRd   = 1'b0;
    expDone = 0;
    expErr  = 1'b0;
    expMis  = 1'b0;
    expTo   = 1'b0;
    accepts = 0;
    issueLen = 0;
    pHeld   = 1'b0;
    pTo     = 1'b0;
    toDelta = -1;
    firstDvaSeen = 1'b0;
    firstRdSeen  = 1'b0;
    firstDvaCyc  = -100;
    rdIssueCyc   = 0;
    #1;
    check("resetBus",
          {MCmd, MAddrSpace, MByteEn, MAddr, MData}, '0);
    check("resetStatus",
          {busy, doneCount, errS, misS, toS}, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic waitFor(
    input string name,
    input int    which,
    input int    target,
    input int    bound
  );
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      #1;
      case (which)
        0:       hit = (int'(doneCount) >= target);
        1:       hit = (accepts >= target);
        default: hit = !busy;
      endcase
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: wait expired after %0d cycles",
               name, bound);
    end
  endtask

  task automatic checkModel(input string name);
    check({name, "_done"}, doneCount, 64'(expDone % 65536));
    check({name, "_flags"}, {errS, misS, toS},
          {expErr, expMis, expTo});
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic runPairs(input string name, input int n);
    @(posedge clk);
    #1 enable = 1'b1;
    waitFor({name, "_done"}, 0, n, 60 * n + 200);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor({name, "_idle"}, 2, 0, 200);
  endtask

  logic [19:0] expWrAddr [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    expWrAddr = '{20'h10, 20'h14, 20'h18, 20'h1C, 20'h10};

    // First pair: latency, data seed, read-back address.
    doReset();
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("firstCmdLatency", MCmd, 1);
    waitFor("s1_done", 0, 1, 200);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor("s1_idle", 2, 0, 200);
    check("s1_wrAddr", wrAddrLog[0], 20'h10);
    check("s1_wrData", wrDataLog[0], 32'hACE10001);
    check("s1_rdAddr", rdAddrLog[0], 20'h10);
    check("s1_rdLatency", rdIssueCyc - firstDvaCyc, GAP + 1);
    check("s1_doneLit", doneCount, 1);
    check("s1_flagsLit", {errS, misS, toS}, 0);
    checkModel("s1");

    // Five pairs: address wrap and LFSR progression.
    doReset();
    runPairs("s2", 5);
    check("s2_wrCount", wrAddrLog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wrAddrLog.size())
        check($sformatf("s2_wrAddr%0d", i),
              wrAddrLog[i], expWrAddr[i]);
    if (wrDataLog.size() >= 3) begin
      check("s2_wrData1", wrDataLog[1], 32'hD6508003);
      check("s2_wrData2", wrDataLog[2], 32'hEB084002);
    end
    check("s2_doneLit", doneCount, 5);
    checkModel("s2");

    // Thread busy held for 7 cycles on the first write.
    doReset();
    @(posedge clk);
    #1;
    enable      = 1'b1;
    SThreadBusy = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 SThreadBusy = 1'b0;
    waitFor("s3_done", 0, 1, 200);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor("s3_idle", 2, 0, 200);
    check("s3_issueLen", issueLens[0], 8);
    check("s3_accepts", accepts, 2);
    checkModel("s3");

    // No response: timeout, read skipped, next write advances.
    doReset();
    dirQ.push_back('{kind: 2'd0, delay: 0, corrupt: 1'b0});
    @(posedge clk);
    #1 enable = 1'b1;
    waitFor("s4_done1", 0, 1, 300);
    check("s4_readSkipped", accepts, 1);
    check("s4_timeout", toS, 1);
    check("s4_toDelta", toDelta, TMO);
    waitFor("s4_done2", 0, 2, 300);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor("s4_idle", 2, 0, 200);
    check("s4_wrAddr1", wrAddrLog[1], 20'h14);
    check("s4_doneLit", doneCount, 2);
    checkModel("s4");

    // Corrupted read-back, then ERR on the next write.
    doReset();
    dirQ.push_back('{kind: 2'd1, delay: 2, corrupt: 1'b0});
    dirQ.push_back('{kind: 2'd1, delay: 1, corrupt: 1'b1});
    dirQ.push_back('{kind: 2'd3, delay: 3, corrupt: 1'b0});
    @(posedge clk);
    #1 enable = 1'b1;
    waitFor("s5_done1", 0, 1, 200);
    check("s5_mismatch", {errS, misS}, 2'b01);
    waitFor("s5_done2", 0, 2, 200);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor("s5_idle", 2, 0, 200);
    check("s5_flagsLit", {errS, misS, toS}, 3'b110);
    check("s5_accepts", accepts, 3);
    checkModel("s5");

    // Enable dropped after write accept; then async reset mid-wait.
    doReset();
    @(posedge clk);
    #1 enable = 1'b1;
    waitFor("s6_acc1", 1, 1, 50);
    @(posedge clk);
    #1 enable = 1'b0;
    waitFor("s6_idle", 2, 0, 200);
    check("s6_readIssued", accepts, 2);
    check("s6_doneLit", doneCount, 1);
    checkModel("s6");
    dirQ.push_back('{kind: 2'd0, delay: 0, corrupt: 1'b0});
    @(posedge clk);
    #1 enable = 1'b1;
    waitFor("s6_acc3", 1, 3, 50);
    @(posedge clk);
    #3;
    check("s6_inWait", {busy, MCmd}, {1'b1, 3'd0});
    reset = 1'b0;
    #1;
    check("s6_asyncBus",
          {MCmd, MAddrSpace, MByteEn, MAddr, MData}, '0);
    check("s6_asyncStatus",
          {busy, doneCount, errS, misS, toS}, '0);
    doReset();
    runPairs("s7", 1);
    check("s7_wrData0", wrDataLog[0], 32'hACE10001);
    checkModel("s7");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
